rename_table: RTL
=================

# rename_table

Speculative and committed register alias table for the integer rename stage. It maps each decoded micro-op's architectural `rs1`, `rs2` and `rd` to physical registers. It requests fresh destination registers from the free list and passes the previous destination mapping (`pre_prd`) downstream to the ROB, which later returns it to the free list. A committed copy of the table, updated by ROB commits, is restored in one cycle on `recover`.

## Interface
- `RENAME_WIDTH`, default `` `RENAME_WIDTH `` (4): micro-ops renamed per cycle
- `COMMIT_WIDTH`, default `` `COMMIT_WIDTH `` (4): commits per cycle
- `ARF_SIZE`, default 32: architectural registers
- `PRF_INT_INDEX_SIZE`, default `` `PRF_INT_INDEX_SIZE `` (6): physical index width
- `clock`  in  1  single clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  downstream back-pressure; freezes the block
- `recover`  in  1  mispredict/exception flush
- `uop_valid`  in  [RENAME_WIDTH]  incoming micro-op valid
- `rs1`, `rs2`, `rd`  in  [RENAME_WIDTH][5]  architectural indices
- `rd_valid`  in  [RENAME_WIDTH]  micro-op writes `rd`
- `prf_req`  out  [RENAME_WIDTH]  combinational request to the free list
- `prf_in`  in  [RENAME_WIDTH][PRF_INT_INDEX_SIZE]  granted registers, slot-aligned with `prf_req`
- `allocatable`  in  1  free list can satisfy all requests this cycle
- `rename_ready`  out  1  group accepted this cycle
- `out_valid`  out  [RENAME_WIDTH]  registered
- `prs1`, `prs2`, `prd`, `pre_prd`  out  [RENAME_WIDTH][PRF_INT_INDEX_SIZE]  registered
- `out_prd_valid`  out  [RENAME_WIDTH]  registered: slot allocated a new `prd`
- `commit_valid`  in  [COMMIT_WIDTH]  ROB commit
- `commit_rd`  in  [COMMIT_WIDTH][5]
- `commit_prd`  in  [COMMIT_WIDTH][PRF_INT_INDEX_SIZE]

## Operation
- State:
  - `spec_rat[ARF_SIZE]` and `arch_rat[ARF_SIZE]`, each PRF_INT_INDEX_SIZE wide.
  - Output register bank.
- Allocation: `prf_req[i] = uop_valid[i] & rd_valid[i] & (rd[i] != 0)`. x0 never allocates. For an x0 slot, `prd = 0` and `pre_prd = 0`.
- Sources: `prs1[i]` and `prs2[i]` read `spec_rat`, then bypass from the nearest lower slot `j < i` with `prf_req[j]` and `rd[j]` equal to the source; the bypassed value is `prf_in[j]`. Source index 0 always yields 0.
- `pre_prd[i]`: `spec_rat[rd[i]]`, overridden by `prf_in[j]` of the nearest lower slot `j` with the same `rd`.
- Acceptance: `accept = !stall & !recover & allocatable`. `rename_ready = accept`.
- On `accept`:
  - `spec_rat[rd[i]] <= prf_in[i]` for each requesting slot; the highest slot wins on duplicate `rd`.
  - The output register loads all fields, with `out_valid = uop_valid`.
- Not accepted:
  - With `stall`, the output register holds.
  - Otherwise (`!allocatable`), `out_valid <= 0` (bubble) and `spec_rat` is unchanged.
- Commit: processed every cycle regardless of `stall`. `arch_rat[commit_rd[k]] <= commit_prd[k]` for each valid slot with `commit_rd != 0`; the highest slot wins on duplicate `rd`.
- Recover: `spec_rat <=` the commit-updated `arch_rat` value of this same cycle. `out_valid <= 0`. Rename inputs are ignored. `recover` has priority over `stall`.
- `arch_rat` entry 0 and `spec_rat` entry 0 are hard-wired to 0.

## Timing
- Rename latency is 1 cycle: inputs at edge N appear on the outputs after edge N.
- `prf_req` and `rename_ready` are combinational from the current inputs and state.
- Reset:
  - All `spec_rat` and `arch_rat` entries = 0, matching the free list reset that marks only p0 busy.
  - `out_valid = 0`, `out_prd_valid = 0`; all index outputs = 0.
  - Reset has priority over `recover`, `stall` and commits.
- A commit and a rename in the same cycle are independent; the commit does not bypass into `spec_rat`.
- With `stall` high for M cycles, the outputs stay constant and no `spec_rat` writes occur.

## Test plan
- Reset, then rename `add x1,x2,x3` with `prf_in[0] = 5` -> next cycle `prs1 = 0`, `prs2 = 0`, `prd = 5`, `pre_prd = 0`, `out_valid = 4'b0001`.
- Group of two in one cycle: `x1 <= x2` gets 7, then `x2 <= x1` gets 8 -> slot1 `prs1 = 7`, slot1 `pre_prd` = old x2 mapping; afterwards `spec_rat[x2] = 8`.
- Two slots both writing x4 with grants 9 and 10 -> slot1 `pre_prd = 9`; afterwards `spec_rat[x4] = 10`.
- `allocatable = 0` for 2 cycles -> `rename_ready = 0`, two bubble cycles (`out_valid = 0`), `spec_rat` unchanged.
- `stall` for 3 cycles -> outputs frozen, no map change; a commit of x1 -> 12 during the stall still lands in `arch_rat`.
- Rename x1 -> 5, commit x1 -> 3 in the same cycle as `recover` -> subsequent read of x1 gives 3, and `out_valid` is 0 in the cycle after `recover`.

Source files
------------

// File: rtl/rename_table.sv
// rename_table: speculative and committed register alias tables for the
// integer rename stage. Sources and previous destination mappings are read
// from the speculative table with intra-group bypass. Fresh destinations
// come from the free list. The committed table is copied back on recover.
//
// Handshake: prf_req is a combinational request to the free list. The group
// is consumed only on a cycle where rename_ready (= !stall & !recover &
// allocatable) is high. There is no valid/ready hold on the output bank; the
// consumer back-pressures it with stall.

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif

module rename_table #(
    parameter int RENAME_WIDTH       = `RENAME_WIDTH,
    parameter int COMMIT_WIDTH       = `COMMIT_WIDTH,
    parameter int ARF_SIZE           = 32,
    parameter int PRF_INT_INDEX_SIZE = `PRF_INT_INDEX_SIZE
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              stall,
    input  logic                                              recover,
    input  logic [RENAME_WIDTH-1:0]                           uop_valid,
    input  logic [RENAME_WIDTH-1:0][4:0]                      rs1,
    input  logic [RENAME_WIDTH-1:0][4:0]                      rs2,
    input  logic [RENAME_WIDTH-1:0][4:0]                      rd,
    input  logic [RENAME_WIDTH-1:0]                           rd_valid,
    output logic [RENAME_WIDTH-1:0]                           prf_req,
    input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prf_in,
    input  logic                                              allocatable,
    output logic                                              rename_ready,
    output logic [RENAME_WIDTH-1:0]                           out_valid,
    output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prs1,
    output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prs2,
    output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prd,
    output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   pre_prd,
    output logic [RENAME_WIDTH-1:0]                           out_prd_valid,
    input  logic [COMMIT_WIDTH-1:0]                           commit_valid,
    input  logic [COMMIT_WIDTH-1:0][4:0]                      commit_rd,
    input  logic [COMMIT_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   commit_prd
);

    localparam int PW = PRF_INT_INDEX_SIZE;

    // Alias tables and their next-state values.
    logic [PW-1:0] spec_rat  [ARF_SIZE];
    logic [PW-1:0] arch_rat  [ARF_SIZE];
    logic [PW-1:0] spec_next [ARF_SIZE];
    logic [PW-1:0] arch_next [ARF_SIZE];

    // Combinational rename results for the current group.
    logic [RENAME_WIDTH-1:0][PW-1:0] prs1_c;
    logic [RENAME_WIDTH-1:0][PW-1:0] prs2_c;
    logic [RENAME_WIDTH-1:0][PW-1:0] prd_c;
    logic [RENAME_WIDTH-1:0][PW-1:0] pre_prd_c;

    logic accept;

    // Request a new register for every live slot writing a non-x0 destination.
    always_comb begin
        prf_req = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            prf_req[i] = uop_valid[i] & rd_valid[i] & (rd[i] != 5'd0);
        end
    end

    // The group is taken only when nothing blocks it and the free list can
    // serve every request.
    always_comb begin
        accept       = !stall && !recover && allocatable;
        rename_ready = accept;
    end

    // Source and previous-destination lookup with bypass from lower slots.
    // Walking j upwards leaves the nearest lower writer as the final value.
    always_comb begin
        prs1_c    = '0;
        prs2_c    = '0;
        prd_c     = '0;
        pre_prd_c = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            prs1_c[i]    = spec_rat[rs1[i]];
            prs2_c[i]    = spec_rat[rs2[i]];
            pre_prd_c[i] = spec_rat[rd[i]];
            for (int j = 0; j < i; j++) begin
                if (prf_req[j] && (rd[j] == rs1[i])) begin
                    prs1_c[i] = prf_in[j];
                end
                if (prf_req[j] && (rd[j] == rs2[i])) begin
                    prs2_c[i] = prf_in[j];
                end
                if (prf_req[j] && (rd[j] == rd[i])) begin
                    pre_prd_c[i] = prf_in[j];
                end
            end
            // x0 maps to p0 regardless of any bypass candidate.
            if (rs1[i] == 5'd0) begin
                prs1_c[i] = '0;
            end
            if (rs2[i] == 5'd0) begin
                prs2_c[i] = '0;
            end
            // Slots without a fresh destination have nothing to free later.
            if (prf_req[i]) begin
                prd_c[i] = prf_in[i];
            end else begin
                pre_prd_c[i] = '0;
            end
        end
    end

    // Committed table next state; later commit slots override earlier ones.
    always_comb begin
        arch_next = arch_rat;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k] && (commit_rd[k] != 5'd0)) begin
                arch_next[commit_rd[k]] = commit_prd[k];
            end
        end
        arch_next[0] = '0;
    end

    // Speculative table next state: recover copies the commit-updated
    // committed table, an accepted group writes its grants (highest slot wins).
    always_comb begin
        spec_next = spec_rat;
        if (recover) begin
            spec_next = arch_next;
        end else if (accept) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (prf_req[i]) begin
                    spec_next[rd[i]] = prf_in[i];
                end
            end
        end
        spec_next[0] = '0;
    end

    // Alias table registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < ARF_SIZE; a++) begin
                spec_rat[a] <= '0;
                arch_rat[a] <= '0;
            end
        end else begin
            spec_rat <= spec_next;
            arch_rat <= arch_next;
        end
    end

    // Output register bank: load on accept, hold on stall, bubble otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid     <= '0;
            out_prd_valid <= '0;
            prs1          <= '0;
            prs2          <= '0;
            prd           <= '0;
            pre_prd       <= '0;
        end else if (recover) begin
            out_valid     <= '0;
            out_prd_valid <= '0;
        end else if (stall) begin
            out_valid     <= out_valid;
            out_prd_valid <= out_prd_valid;
        end else if (accept) begin
            out_valid     <= uop_valid;
            out_prd_valid <= prf_req;
            prs1          <= prs1_c;
            prs2          <= prs2_c;
            prd           <= prd_c;
            pre_prd       <= pre_prd_c;
        end else begin
            out_valid     <= '0;
            out_prd_valid <= '0;
        end
    end

endmodule
